// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: registers the decoded control bundle into EX,
// detects load-use hazards against EX, inserts bubbles on stall or branch
// flush, honours the global memory hold and counts inserted hazard bubbles.
module id_ex_stage #(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc,
    input  logic [1:0]       id_srd,
    input  logic [1:0]       id_psw_le_re,
    input  logic             id_b,
    input  logic [2:0]       id_soh_op,
    input  logic [3:0]       id_alu_op,
    input  logic [3:0]       id_ram_ctrl,
    input  logic             id_l,
    input  logic             id_rf_le,
    input  logic [1:0]       id_sr,
    input  logic             id_ub,
    input  logic             ex_branch_taken,
    input  logic             mem_hold,
    input  logic             cnt_clr,
    output logic [1:0]       ex_psw_le_re,
    output logic             ex_b,
    output logic [2:0]       ex_soh_op,
    output logic [3:0]       ex_alu_op,
    output logic [3:0]       ex_ram_ctrl,
    output logic             ex_l,
    output logic             ex_rf_le,
    output logic             ex_ub,
    output logic [31:0]      ex_instr,
    output logic [31:0]      ex_pc,
    output logic [4:0]       ex_rd,
    output logic             ex_valid,
    output logic             stall_out,
    output logic             if_id_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_BUBBLE = 2'b01,
        S_HOLD   = 2'b10
    } state_t;

    // What the EX register does on the next edge.
    typedef enum logic [1:0] {
        EX_LOAD   = 2'b00,
        EX_BUBBLE = 2'b01,
        EX_KEEP   = 2'b10
    } ex_op_t;

    typedef struct packed {
        logic [1:0] psw_le_re;
        logic       b;
        logic [2:0] soh_op;
        logic [3:0] alu_op;
        logic [3:0] ram_ctrl;
        logic       l;
        logic       rf_le;
        logic       ub;
    } ctrl_t;

    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl_q;
    logic [31:0]      ex_instr_q;
    logic [31:0]      ex_pc_q;
    logic [4:0]       ex_rd_q;
    logic             ex_valid_q;
    state_t           state_q;
    state_t           state_d;
    ex_op_t           ex_op;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;
    logic [4:0]       id_rd;
    logic             id_nop;
    logic             lu;
    logic             stall;
    logic             flush;

    assign id_ctrl = '{psw_le_re: id_psw_le_re, b: id_b, soh_op: id_soh_op,
                       alu_op: id_alu_op, ram_ctrl: id_ram_ctrl, l: id_l,
                       rf_le: id_rf_le, ub: id_ub};

    assign id_nop = (id_instr == 32'h0);

    // Destination register select driven by the control unit's SRD field.
    always_comb begin
        id_rd = 5'd0;
        case (id_srd)
            2'b00:   id_rd = id_instr[4:0];
            2'b01:   id_rd = id_instr[25:21];
            2'b10:   id_rd = id_instr[20:16];
            default: id_rd = 5'd0;
        endcase
    end

    // Load-use: a valid load in EX writes a register the ID instruction reads.
    always_comb begin
        lu = ex_valid_q & ex_ctrl_q.l & ex_ctrl_q.rf_le & (ex_rd_q != 5'd0) & ~id_nop &
             ((id_sr[1] & (id_instr[25:21] == ex_rd_q)) |
              (id_sr[0] & (id_instr[20:16] == ex_rd_q)));
    end

    // Next-state and pipeline-control decode; hold beats flush beats load-use.
    // Every state obeys the same priorities, so the decision ignores state_q.
    always_comb begin
        state_d = S_RUN;
        ex_op   = EX_LOAD;
        stall   = 1'b0;
        flush   = 1'b0;
        cnt_inc = 1'b0;
        if (mem_hold) begin
            ex_op   = EX_KEEP;
            stall   = 1'b1;
            state_d = S_HOLD;
        end else if (ex_branch_taken) begin
            flush = 1'b1;
            if (DELAY_SLOT == 0) begin
                ex_op   = EX_BUBBLE;
                cnt_inc = 1'b1;
                state_d = S_BUBBLE;
            end
        end else if (lu) begin
            stall   = 1'b1;
            ex_op   = EX_BUBBLE;
            cnt_inc = 1'b1;
            state_d = S_BUBBLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // EX register bank: load ID, insert a bubble, or freeze under hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q  <= '0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
            ex_rd_q    <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            case (ex_op)
                EX_BUBBLE: begin
                    ex_ctrl_q  <= '0;
                    ex_instr_q <= '0;
                    ex_pc_q    <= '0;
                    ex_rd_q    <= '0;
                    ex_valid_q <= 1'b0;
                end
                EX_LOAD: begin
                    // A NOP travels with its PC but carries no control or destination.
                    ex_ctrl_q  <= id_nop ? '0 : id_ctrl;
                    ex_instr_q <= id_instr;
                    ex_pc_q    <= id_pc;
                    ex_rd_q    <= id_nop ? 5'd0 : id_rd;
                    ex_valid_q <= ~id_nop;
                end
                default: ;
            endcase
        end
    end

    // Saturating bubble counter; clear wins over an increment.
    always_ff @(posedge clk) begin
        if (!rst_n)                     cnt_q <= '0;
        else if (cnt_clr)               cnt_q <= '0;
        else if (cnt_inc && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
    end

    assign ex_psw_le_re = ex_ctrl_q.psw_le_re;
    assign ex_b         = ex_ctrl_q.b;
    assign ex_soh_op    = ex_ctrl_q.soh_op;
    assign ex_alu_op    = ex_ctrl_q.alu_op;
    assign ex_ram_ctrl  = ex_ctrl_q.ram_ctrl;
    assign ex_l         = ex_ctrl_q.l;
    assign ex_rf_le     = ex_ctrl_q.rf_le;
    assign ex_ub        = ex_ctrl_q.ub;
    assign ex_instr     = ex_instr_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rd        = ex_rd_q;
    assign ex_valid     = ex_valid_q;
    assign stall_out    = stall;
    assign if_id_flush  = flush;
    assign state        = state_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for the main pipeline flow
// plus hand sequences for reset, delay-slot squash and counter saturation.
module tb_id_ex_stage;

    localparam logic [31:0] ADD  = 32'h08640605; // rs=3 rt=4 rd=5
    localparam logic [31:0] ADD2 = 32'h08670605; // rs=3 rt=7 rd=5
    localparam logic [31:0] LDW  = 32'h48470000; // rs=2 rt=7, dest r7 via SRD=10

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr, id_pc;
    logic [1:0]  id_srd, id_psw_le_re, id_sr;
    logic        id_b, id_l, id_rf_le, id_ub;
    logic [2:0]  id_soh_op;
    logic [3:0]  id_alu_op, id_ram_ctrl;
    logic        ex_branch_taken, mem_hold, cnt_clr;

    logic [1:0]  ex_psw_le_re, d0_psw_le_re;
    logic        ex_b, ex_l, ex_rf_le, ex_ub, d0_b, d0_l, d0_rf_le, d0_ub;
    logic [2:0]  ex_soh_op, d0_soh_op;
    logic [3:0]  ex_alu_op, ex_ram_ctrl, d0_alu_op, d0_ram_ctrl;
    logic [31:0] ex_instr, ex_pc, d0_instr, d0_pc;
    logic [4:0]  ex_rd, d0_rd;
    logic        ex_valid, stall_out, if_id_flush, d0_valid, d0_stall, d0_flush;
    logic [1:0]  state, d0_state;
    logic [15:0] bubble_cnt, d0_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DELAY_SLOT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_pc(id_pc), .id_srd(id_srd),
        .id_psw_le_re(id_psw_le_re), .id_b(id_b), .id_soh_op(id_soh_op),
        .id_alu_op(id_alu_op), .id_ram_ctrl(id_ram_ctrl), .id_l(id_l),
        .id_rf_le(id_rf_le), .id_sr(id_sr), .id_ub(id_ub),
        .ex_branch_taken(ex_branch_taken), .mem_hold(mem_hold), .cnt_clr(cnt_clr),
        .ex_psw_le_re(ex_psw_le_re), .ex_b(ex_b), .ex_soh_op(ex_soh_op),
        .ex_alu_op(ex_alu_op), .ex_ram_ctrl(ex_ram_ctrl), .ex_l(ex_l),
        .ex_rf_le(ex_rf_le), .ex_ub(ex_ub), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_valid(ex_valid), .stall_out(stall_out),
        .if_id_flush(if_id_flush), .state(state), .bubble_cnt(bubble_cnt));

    id_ex_stage #(.DELAY_SLOT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_pc(id_pc), .id_srd(id_srd),
        .id_psw_le_re(id_psw_le_re), .id_b(id_b), .id_soh_op(id_soh_op),
        .id_alu_op(id_alu_op), .id_ram_ctrl(id_ram_ctrl), .id_l(id_l),
        .id_rf_le(id_rf_le), .id_sr(id_sr), .id_ub(id_ub),
        .ex_branch_taken(ex_branch_taken), .mem_hold(mem_hold), .cnt_clr(cnt_clr),
        .ex_psw_le_re(d0_psw_le_re), .ex_b(d0_b), .ex_soh_op(d0_soh_op),
        .ex_alu_op(d0_alu_op), .ex_ram_ctrl(d0_ram_ctrl), .ex_l(d0_l),
        .ex_rf_le(d0_rf_le), .ex_ub(d0_ub), .ex_instr(d0_instr), .ex_pc(d0_pc),
        .ex_rd(d0_rd), .ex_valid(d0_valid), .stall_out(d0_stall),
        .if_id_flush(d0_flush), .state(d0_state), .bubble_cnt(d0_cnt));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  srd;
        logic [1:0]  sr;
        logic        l;
        logic        rf;
        logic [3:0]  alu;
        logic        br;
        logic        hold;
        logic        e_stall;
        logic        e_flush;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [3:0]  e_alu;
        logic [1:0]  e_state;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, logic [1:0] srd,
                                logic [1:0] sr, logic l, logic rf, logic [3:0] alu,
                                logic br, logic hold, logic e_stall, logic e_flush,
                                logic e_valid, logic [4:0] e_rd, logic [31:0] e_instr,
                                logic [31:0] e_pc, logic [3:0] e_alu, logic [1:0] e_state,
                                logic [15:0] e_cnt);
        vec_t v;
        v.instr = instr; v.pc = pc; v.srd = srd; v.sr = sr; v.l = l; v.rf = rf;
        v.alu = alu; v.br = br; v.hold = hold; v.e_stall = e_stall; v.e_flush = e_flush;
        v.e_valid = e_valid; v.e_rd = e_rd; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_alu = e_alu; v.e_state = e_state; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] srd,
                          input logic [1:0] sr, input logic l, input logic rf, input logic [3:0] alu);
        id_instr = instr; id_pc = pc; id_srd = srd; id_sr = sr;
        id_l = l; id_rf_le = rf; id_alu_op = alu;
    endtask

    // All registered EX outputs of the DELAY_SLOT=1 instance are zero.
    task automatic chk_ex_zero(input string tag);
        chk({tag, " ctrl"}, {ex_psw_le_re, ex_b, ex_soh_op, ex_alu_op, ex_ram_ctrl,
                             ex_l, ex_rf_le, ex_ub}, 64'h0);
        chk({tag, " instr"}, ex_instr, 64'h0);
        chk({tag, " pc"}, ex_pc, 64'h0);
        chk({tag, " rd"}, ex_rd, 64'h0);
        chk({tag, " valid"}, ex_valid, 64'h0);
        chk({tag, " state"}, state, 64'h0);
        chk({tag, " cnt"}, bubble_cnt, 64'h0);
    endtask

    initial begin
        // Control fields not under test are held non-zero so zeroing is visible.
        id_psw_le_re = 2'b11; id_b = 1'b1; id_soh_op = 3'b101; id_ram_ctrl = 4'hA; id_ub = 1'b1;
        set_id(ADD, 32'h100, 2'b00, 2'b11, 1'b0, 1'b1, 4'h0);
        ex_branch_taken = 1'b0; mem_hold = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk_ex_zero("reset");
        rst_n = 1'b1;

        //            instr pc       srd    sr     l  rf alu br hold | st fl v  rd  instr pc       alu st     cnt
        vecs[0]  = mk(ADD,  32'h100, 2'b00, 2'b11, 0, 1, 0, 0, 0,   0, 0, 1, 5, ADD,  32'h100, 0, 2'd0, 0);
        vecs[1]  = mk(LDW,  32'h104, 2'b10, 2'b10, 1, 1, 1, 0, 0,   0, 0, 1, 7, LDW,  32'h104, 1, 2'd0, 0);
        vecs[2]  = mk(ADD2, 32'h108, 2'b00, 2'b11, 0, 1, 2, 0, 0,   1, 0, 0, 0, 0,    32'h0,   0, 2'd1, 1);
        vecs[3]  = mk(ADD2, 32'h108, 2'b00, 2'b11, 0, 1, 2, 0, 0,   0, 0, 1, 5, ADD2, 32'h108, 2, 2'd0, 1);
        vecs[4]  = mk(ADD,  32'h10C, 2'b00, 2'b11, 0, 1, 0, 1, 0,   0, 1, 1, 5, ADD,  32'h10C, 0, 2'd0, 1);
        vecs[5]  = mk(0,    32'h110, 2'b00, 2'b00, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,    32'h0,   0, 2'd0, 1);
        vecs[6]  = mk(LDW,  32'h114, 2'b10, 2'b10, 1, 1, 1, 0, 0,   0, 0, 1, 7, LDW,  32'h114, 1, 2'd0, 1);
        vecs[7]  = mk(ADD2, 32'h118, 2'b00, 2'b11, 0, 1, 2, 1, 1,   1, 0, 1, 7, LDW,  32'h114, 1, 2'd2, 1);
        vecs[8]  = mk(ADD2, 32'h118, 2'b00, 2'b11, 0, 1, 2, 1, 0,   0, 1, 1, 5, ADD2, 32'h118, 2, 2'd0, 1);
        vecs[9]  = mk(LDW,  32'h11C, 2'b10, 2'b10, 1, 1, 1, 0, 0,   0, 0, 1, 7, LDW,  32'h11C, 1, 2'd0, 1);
        vecs[10] = mk(ADD2, 32'h120, 2'b00, 2'b11, 0, 1, 2, 0, 1,   1, 0, 1, 7, LDW,  32'h11C, 1, 2'd2, 1);
        vecs[11] = mk(ADD2, 32'h120, 2'b00, 2'b11, 0, 1, 2, 0, 0,   1, 0, 0, 0, 0,    32'h0,   0, 2'd1, 2);
        vecs[12] = mk(ADD2, 32'h120, 2'b00, 2'b11, 0, 1, 2, 0, 0,   0, 0, 1, 5, ADD2, 32'h120, 2, 2'd0, 2);
        vecs[13] = mk(ADD,  32'h124, 2'b01, 2'b11, 0, 1, 0, 0, 0,   0, 0, 1, 3, ADD,  32'h124, 0, 2'd0, 2);
        vecs[14] = mk(ADD,  32'h128, 2'b11, 2'b11, 0, 1, 0, 0, 0,   0, 0, 1, 0, ADD,  32'h128, 0, 2'd0, 2);

        foreach (vecs[i]) begin
            set_id(vecs[i].instr, vecs[i].pc, vecs[i].srd, vecs[i].sr, vecs[i].l, vecs[i].rf, vecs[i].alu);
            ex_branch_taken = vecs[i].br;
            mem_hold = vecs[i].hold;
            #1;
            chk($sformatf("v%0d stall_out", i), stall_out, vecs[i].e_stall);
            chk($sformatf("v%0d if_id_flush", i), if_id_flush, vecs[i].e_flush);
            tick();
            chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].e_valid);
            chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].e_rd);
            chk($sformatf("v%0d ex_instr", i), ex_instr, vecs[i].e_instr);
            chk($sformatf("v%0d ex_alu_op", i), ex_alu_op, vecs[i].e_alu);
            chk($sformatf("v%0d state", i), state, vecs[i].e_state);
            chk($sformatf("v%0d bubble_cnt", i), bubble_cnt, vecs[i].e_cnt);
            if (vecs[i].e_valid)
                chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].e_pc);
        end
        ex_branch_taken = 1'b0; mem_hold = 1'b0;

        // Reset in the middle of a load-use stall (counter is non-zero here).
        set_id(LDW, 32'h200, 2'b10, 2'b10, 1'b1, 1'b1, 4'h1);
        tick();
        set_id(ADD2, 32'h204, 2'b00, 2'b11, 1'b0, 1'b1, 4'h2);
        #1;
        chk("pre-reset stall_out", stall_out, 1);
        rst_n = 1'b0;
        tick();
        chk_ex_zero("reset mid-stall");
        rst_n = 1'b1;

        // Taken branch with ADD in ID: delay slot kept vs squashed.
        set_id(ADD, 32'h300, 2'b00, 2'b11, 1'b0, 1'b1, 4'h0);
        ex_branch_taken = 1'b1;
        #1;
        chk("ds0 if_id_flush", d0_flush, 1);
        chk("ds0 stall_out", d0_stall, 0);
        tick();
        chk("ds1 ex_valid", ex_valid, 1);
        chk("ds1 bubble_cnt", bubble_cnt, 0);
        chk("ds0 ex_valid", d0_valid, 0);
        chk("ds0 ex_instr", d0_instr, 0);
        chk("ds0 bubble_cnt", d0_cnt, 1);
        chk("ds0 state", d0_state, 2'b01);
        ex_branch_taken = 1'b0;

        // cnt_clr in the same cycle as a load-use wins over the increment.
        set_id(LDW, 32'h304, 2'b10, 2'b10, 1'b1, 1'b1, 4'h1);
        tick();
        set_id(ADD2, 32'h308, 2'b00, 2'b11, 1'b0, 1'b1, 4'h2);
        tick();
        chk("lu cnt before clr", bubble_cnt, 1);
        set_id(LDW, 32'h30C, 2'b10, 2'b10, 1'b1, 1'b1, 4'h1);
        tick();
        set_id(ADD2, 32'h310, 2'b00, 2'b11, 1'b0, 1'b1, 4'h2);
        cnt_clr = 1'b1;
        #1;
        chk("clr+lu stall_out", stall_out, 1);
        tick();
        cnt_clr = 1'b0;
        chk("clr+lu bubble_cnt", bubble_cnt, 0);
        chk("clr+lu ex_valid", ex_valid, 0);

        // Saturation: a squashed delay slot bubbles every cycle on dut0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_id(ADD, 32'h400, 2'b00, 2'b11, 1'b0, 1'b1, 4'h0);
        ex_branch_taken = 1'b1;
        for (int n = 0; n < 65534; n++) tick();
        chk("sat cnt FFFE", d0_cnt, 16'hFFFE);
        tick();
        chk("sat cnt FFFF", d0_cnt, 16'hFFFF);
        tick(); tick(); tick();
        chk("sat cnt holds", d0_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat clr wins", d0_cnt, 0);
        ex_branch_taken = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary directly downstream of the control unit.
- Registers the decoded control bundle, instruction, PC and resolved destination register into EX.
- Detects load-use hazards against the instruction currently in EX and stalls upstream.
- Inserts NOP bubbles on stall or branch flush, honours a global memory hold, and counts hazard bubbles.

Parameters:
DELAY_SLOT, 1, 1 = instruction in ID when a branch is taken in EX executes (delay slot); 0 = it is squashed
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_instr  in  32  instruction in ID (32'h0 = NOP)
id_pc  in  32  PC of id_instr
id_srd  in  2  SRD from control unit
id_psw_le_re  in  2  PSW load/read enable
id_b  in  1  branch
id_soh_op  in  3  operand handler opcode
id_alu_op  in  4  ALU opcode
id_ram_ctrl  in  4  RAM control
id_l  in  1  select RAM dataout
id_rf_le  in  1  register file load enable
id_sr  in  2  source usage: [1]=I[25:21] read, [0]=I[20:16] read
id_ub  in  1  unconditional branch
ex_branch_taken  in  1  branch resolved taken in EX this cycle
mem_hold  in  1  global stall from memory
cnt_clr  in  1  synchronous clear of bubble counter
ex_* (psw_le_re, b, soh_op, alu_op, ram_ctrl, l, rf_le, ub)  out  same widths  registered control to EX
ex_instr  out  32  registered instruction
ex_pc  out  32  registered PC
ex_rd  out  5  registered destination register
ex_valid  out  1  EX holds a real instruction
stall_out  out  1  combinational: hold PC and IF/ID
if_id_flush  out  1  combinational: zero IF/ID next edge
state  out  2  FSM state: 00 RUN, 01 BUBBLE, 10 HOLD
bubble_cnt  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0 at edge): all ex_* and ex_instr, ex_pc, ex_rd = 0; ex_valid=0; state=RUN; bubble_cnt=0. Reset dominates every other input, including mid-stall or mid-hold.
- Destination decode, combinational on ID:
  - SRD 00 -> I[4:0]
  - SRD 01 -> I[25:21]
  - SRD 10 -> I[20:16]
  - SRD 11 -> 0
- id_nop = (id_instr==0). A NOP loads ex_valid=0 and all-zero control.
- Load-use condition lu = ex_valid & ex_l & ex_rf_le & (ex_rd!=0) & ~id_nop & ((id_sr[1] & I[25:21]==ex_rd) | (id_sr[0] & I[20:16]==ex_rd)).
- Priority per cycle, one edge each, latency 1:
  - mem_hold=1: EX registers unchanged; stall_out=1; if_id_flush=0; next state HOLD. A branch or lu in the same cycle is re-evaluated once hold drops.
  - else ex_branch_taken=1: if_id_flush=1; stall_out=0. If DELAY_SLOT=1, ID loads into EX normally. If DELAY_SLOT=0, a bubble loads into EX and bubble_cnt increments. Next state is RUN, or BUBBLE when a bubble was inserted.
  - else lu=1: stall_out=1; bubble into EX (all control 0, ex_valid=0, ex_rd=0, ex_instr=0); bubble_cnt increments; next state BUBBLE.
  - else: ID loads into EX; ex_valid = ~id_nop; next state RUN.
- BUBBLE lasts one cycle. lu cannot recur for the same pair because ex_valid=0. State returns to RUN unless a new condition arises.
- HOLD -> RUN on the first cycle with mem_hold=0, which follows the priorities above.
- bubble_cnt:
  - Saturates at all-ones.
  - cnt_clr=1 forces 0 and wins over an increment in the same cycle.
  - Does not count while mem_hold=1.
- stall_out and if_id_flush are never both 1.

Test Plan:
- Reset mid-stall: assert lu, drop rst_n for one edge -> ex_* = 0, ex_valid=0, state=00, bubble_cnt=0.
- id_instr=32'h08640605 (ADD r3,r4 -> r5, SRD=00) -> next edge ex_rd=5, ex_alu_op=0000, ex_rf_le=1, ex_valid=1, stall_out=0.
- LDW 32'h48470000 (SRD=10, dest r7, l=1) into EX, then ADD with I[20:16]=7, id_sr=11 in ID -> stall_out=1; next edge ex_valid=0, state=01, bubble_cnt=1; following edge the ADD enters EX with stall_out=0.
- ex_branch_taken=1 with ADD in ID, DELAY_SLOT=1 -> if_id_flush=1, ADD enters EX. With DELAY_SLOT=0 -> ex_valid=0 and bubble_cnt increments.
- mem_hold=1 together with ex_branch_taken=1 and lu -> EX unchanged, stall_out=1, if_id_flush=0, state=10, bubble_cnt unchanged. After the hold drops, the flush fires.
- Preload bubble_cnt to 16'hFFFF via repeated lu -> stays FFFF. cnt_clr=1 together with lu -> bubble_cnt=0.
